// File: rtl/mult_share_arbiter.sv
// Round-robin front end that time-shares one combinational 16x16 multiplier
// between NUM_REQ requesters, returning tagged products over a valid/ready port.
module mult_share_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [16*NUM_REQ-1:0]   multiplicand_in,
   input  logic [16*NUM_REQ-1:0]   multiplier_in,
   output logic [NUM_REQ-1:0]      grant,
   output logic                    busy,
   output logic [31:0]             result,
   output logic [ID_W-1:0]         result_id,
   output logic                    result_valid,
   input  logic                    result_ready
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_reg, state_next;
   logic [ID_W-1:0]   last_id_reg;
   logic [ID_W-1:0]   winner_reg;
   logic [15:0]       op_a_reg, op_b_reg;
   logic [15:0]       a_arr [NUM_REQ];
   logic [15:0]       b_arr [NUM_REQ];
   logic              win_found;
   logic [ID_W-1:0]   win_idx;
   logic [31:0]       product;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = multiplicand_in[16*gi +: 16];
      assign b_arr[gi] = multiplier_in[16*gi +: 16];
   end

   // First requester at or after last_id+1, wrapping modulo NUM_REQ.
   always_comb begin
      int cand;
      cand      = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = (int'(last_id_reg) + i) % NUM_REQ;
         if (!win_found && req[ID_W'(cand)]) begin
            win_found = 1'b1;
            win_idx   = ID_W'(cand);
         end
      end
   end

   // The shared multiplier only ever sees the captured operands.
   assign product = {16'b0, op_a_reg} * {16'b0, op_b_reg};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (win_found) state_next = CALC;
         CALC:    state_next = DONE;
         DONE:    if (result_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_id_reg  <= ID_W'(NUM_REQ - 1);
         winner_reg   <= '0;
         op_a_reg     <= '0;
         op_b_reg     <= '0;
         grant        <= '0;
         result       <= '0;
         result_id    <= '0;
         result_valid <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (win_found) begin
                  op_a_reg    <= a_arr[win_idx];
                  op_b_reg    <= b_arr[win_idx];
                  grant       <= NUM_REQ'(1) << win_idx;
                  last_id_reg <= win_idx;
                  winner_reg  <= win_idx;
               end
            end
            CALC: begin
               result       <= product;
               result_id    <= winner_reg;
               result_valid <= 1'b1;
               grant        <= '0;
            end
            DONE: begin
               if (result_ready) result_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomised directed bench for mult_share_arbiter; expectations come from a
// priority-queue model of round-robin order and plain integer multiplication.
module tb_mult_share_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [63:0] mcand;
   logic [63:0] mplier;
   logic [3:0]  grant;
   logic        busy;
   logic [31:0] result;
   logic [1:0]  result_id;
   logic        result_valid;
   logic        result_ready;

   int total;
   int passed;
   int prio[$];

   mult_share_arbiter #(.NUM_REQ(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req             (req),
      .multiplicand_in (mcand),
      .multiplier_in   (mplier),
      .grant           (grant),
      .busy            (busy),
      .result          (result),
      .result_id       (result_id),
      .result_valid    (result_valid),
      .result_ready    (result_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Priority list: front is most favoured; a winner moves to the back.
   function automatic int pick(input logic [3:0] m);
      int w;
      w = -1;
      foreach (prio[i]) if (w < 0 && m[prio[i]]) w = prio[i];
      if (w < 0) return 0;
      while (prio[$] != w) prio.push_back(prio.pop_front());
      return w;
   endfunction

   task automatic issue(input logic [3:0] mask, input int stall, input bit disturb);
      int          w;
      logic [31:0] exp_p;
      w     = pick(mask);
      exp_p = 32'(mcand[16*w +: 16]) * 32'(mplier[16*w +: 16]);
      req          = mask;
      result_ready = (stall == 0);
      @(negedge clk);
      check("grant", 32'(grant), 32'(4'b1 << w));
      check("busy_calc", 32'(busy), 32'd1);
      check("valid_calc", 32'(result_valid), 32'd0);
      if (disturb) begin
         req    = 4'($urandom_range(0, 15));
         mcand  = {$urandom, $urandom};
         mplier = {$urandom, $urandom};
      end
      @(negedge clk);
      check("grant_done", 32'(grant), 32'd0);
      check("valid_done", 32'(result_valid), 32'd1);
      check("result", result, exp_p);
      check("result_id", 32'(result_id), 32'(w));
      for (int s = 0; s < stall; s++) begin
         if (disturb) req = 4'($urandom_range(0, 15));
         @(negedge clk);
         check("hold_valid", 32'(result_valid), 32'd1);
         check("hold_result", result, exp_p);
         check("hold_grant", 32'(grant), 32'd0);
      end
      result_ready = 1'b1;
      if (stall > 0) @(negedge clk);
      if (stall == 0) @(negedge clk);
      check("valid_after", 32'(result_valid), 32'd0);
      check("busy_after", 32'(busy), 32'd0);
      if (disturb) req = 4'b0;
      $display("op mask=%b winner=%0d product=%h stall=%0d", mask, w, exp_p, stall);
   endtask

   initial begin
      logic [3:0] m;
      total        = 0;
      passed       = 0;
      prio         = {0, 1, 2, 3};
      rst_n        = 1'b0;
      req          = '0;
      mcand        = '0;
      mplier       = '0;
      result_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(result_valid), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_id", 32'(result_id), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("idle_grant", 32'(grant), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);

      // Single request
      mcand[15:0] = 16'd3; mplier[15:0] = 16'd5;
      issue(4'b0001, 0, 0);
      check("single_product_const", result, 32'd15);
      req = 4'b0;
      @(negedge clk);
      check("no_req_grant", 32'(grant), 32'd0);

      // Round robin with all requests held
      for (int k = 0; k < 4; k++) begin
         mcand[16*k +: 16]  = 16'(k + 1);
         mplier[16*k +: 16] = 16'h0100;
      end
      for (int n = 0; n < 5; n++) issue(4'b1111, 0, 0);

      // Backpressure with extreme operands
      mcand = '1; mplier = '1;
      issue(4'b1111, 5, 0);
      check("ffff_const", result, 32'hFFFE0001);

      // Operand isolation
      mcand = {$urandom, $urandom}; mplier = {$urandom, $urandom};
      issue(4'b0100, 2, 1);

      // Pointer wrap and skip
      issue(4'b1000, 0, 0);
      issue(4'b0100, 0, 0);
      issue(4'b1001, 0, 0);

      // Random mix
      for (int n = 0; n < 20; n++) begin
         m = 4'($urandom_range(1, 15));
         mcand  = {$urandom, $urandom};
         mplier = {$urandom, $urandom};
         if (n % 5 == 0) mcand[16*(n % 4) +: 16] = 16'h0000;
         if (n % 7 == 0) mplier = '1;
         issue(m, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset while a result is pending
      req = 4'b0010; result_ready = 1'b0;
      mcand = {$urandom, $urandom}; mplier = {$urandom, $urandom};
      @(negedge clk);
      check("pre_rst_grant", 32'(grant), 32'b0010);
      @(negedge clk);
      check("pre_rst_valid", 32'(result_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_grant", 32'(grant), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_valid", 32'(result_valid), 32'd0);
      check("arst_result", result, 32'd0);
      check("arst_id", 32'(result_id), 32'd0);
      prio = {0, 1, 2, 3};
      req  = '0;
      @(negedge clk);
      rst_n = 1'b1;
      issue(4'b1000, 0, 0);
      issue(4'b1111, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
